stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Single-clock controller that sequences a 4-digit BCD counter (digits 0–9999) as a stopwatch, with start/stop, clear and lap (display freeze) commands. It replaces ripple-divided counter clocks with a prescaler-generated count enable, so every register runs on `clk`. It sits between the debounced button/edge-detect front end and the 7-segment display driver.

## Interface
- `DIV`, default 10: `clk` cycles per count increment; legal range ≥2; prescaler width is `$clog2(DIV)`.

- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start_stop`  in  1  single-cycle command pulse: run/pause toggle
- `clear`  in  1  single-cycle command pulse: zero the count (PAUSE only)
- `lap`  in  1  single-cycle command pulse: freeze/release the display
- `q0`  out  4  displayed BCD digit 0 (least significant)
- `q1`  out  4  displayed BCD digit 1
- `q2`  out  4  displayed BCD digit 2
- `q3`  out  4  displayed BCD digit 3 (most significant)
- `running`  out  1  high in RUN and LAP
- `lap_active`  out  1  high in LAP
- `overflow`  out  1  sticky; set on 9999→0000 wrap

## Operation
- Command inputs are synchronous and edge-detected upstream. A level held high counts as one pulse per cycle.
- FSM states are IDLE, RUN, PAUSE and LAP.
  - IDLE: `start_stop`→RUN. `clear` and `lap` are ignored.
  - RUN: `start_stop`→PAUSE. `lap`→LAP and snapshots the live count into the lap registers. `clear` is ignored.
  - LAP: `start_stop`→PAUSE and the display returns to the live count. `lap`→RUN and the display returns to the live count. `clear` is ignored.
  - PAUSE: `clear`→IDLE. `start_stop`→RUN. `lap` is ignored.
- Simultaneous commands:
  - In PAUSE, `clear` beats `start_stop`.
  - In RUN and LAP, `start_stop` beats `lap`, and `lap` is dropped.
- Prescaler `pre`:
  - Advances in RUN and LAP.
  - Holds its value in PAUSE.
  - Is 0 in IDLE.
  - When `pre==DIV-1` while advancing, it asserts `tick` and wraps to 0.
- Count:
  - On `tick`, digit 0 increments.
  - Each digit rolls 9→0 and carries into the next digit in the same cycle.
  - 9999→0000 sets `overflow`.
  - Digits never hold a value above 9.
- `clear` accepted in PAUSE zeroes the count, `pre` and `overflow`.
- Display: `qN` = lap register N in LAP, otherwise live count digit N. This is a combinational mux from registers, with no added latency.

## Timing
- Reset values: state IDLE; `pre`=0; count=0000; lap registers=0000; `q0..q3`=0; `running`=0; `lap_active`=0; `overflow`=0.
- Reset is asynchronous: it takes effect without a clock edge, even mid-RUN.
- `start_stop` sampled at edge N (from IDLE): state is RUN after N, and the count first reads 0001 after edge N+DIV. After that, one increment every DIV cycles.
- Pause and resume are cycle-exact. The prescaler phase is preserved, so the next increment comes DIV−`pre` cycles after the resume edge.
- Lap snapshot captures the count value present before the accepting edge. If `tick` occurs on that same edge, the snapshot holds the pre-increment value.
- `running`, `lap_active` and `overflow` are registered and change on the command/tick edge.

## Structure
- Package `stopwatch_pkg` holds:
  - the 2-bit state enum (IDLE, RUN, PAUSE, LAP);
  - `BCD_MAX`=4'd9;
  - `NUM_DIGITS`=4.
- Sub-module `bcd_digit`: inputs `clk`, `rst`, sync `clr`, `en`; outputs 4-bit `q` and `carry`.
  - `carry` = `en` && `q`==9.
  - Instantiated 4× and chained via carry→en.
- The top level contains the FSM, prescaler, lap registers, display mux and `overflow` flag.

## Test plan
- DIV=4: reset, then pulse `start_stop` at edge 0 → `q`=0001 after edge 4, 0003 after edge 12, `running`=1.
- Pause at `pre`=2 and hold 20 cycles → `q` unchanged. Resume → next increment after exactly 2 cycles.
- Lap while the count is 0005 → `q` holds 0005 and `lap_active`=1 while the internal count reaches 0008. Second `lap` → `q`=0008 immediately, `lap_active`=0.
- Run 10000 ticks → `q`=0000 and `overflow`=1. Pause, then `clear` → `overflow`=0, state IDLE.
- Simultaneous commands:
  - `start_stop`+`clear` in PAUSE → IDLE, `q`=0000, `running`=0.
  - `start_stop`+`lap` in RUN → PAUSE, `lap_active`=0.
  - `clear` in RUN → ignored.
- Assert `rst` mid-RUN between clock edges → all outputs 0 immediately. After deassertion, state stays IDLE until `start_stop`.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         NUM_DIGITS = 4;
endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD decade: sync clear, count enable, carry out on 9->0 roll.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  output logic [3:0] q,
  output logic       carry
);
  logic [3:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)     q_d = 4'd0;
    else if (en) q_d = (q_q >= BCD_MAX) ? 4'd0 : q_q + 4'd1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;

  assign q     = q_q;
  assign carry = en && (q_q == BCD_MAX);
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: FSM, prescaled count enable, BCD chain, lap freeze.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] q0,
  output logic [3:0] q1,
  output logic [3:0] q2,
  output logic [3:0] q3,
  output logic       running,
  output logic       lap_active,
  output logic       overflow
);
  localparam int PW = $clog2(DIV);

  state_e                       state_q, state_d;
  logic [PW-1:0]                pre_q, pre_d;
  logic                         adv, tick, clr_acc, snap;
  logic [NUM_DIGITS-1:0][3:0]   cnt, lap_q, disp;
  logic [NUM_DIGITS:0]          en;
  logic                         ovf_q;

  // start_stop has priority over lap in RUN/LAP; clear over start_stop in PAUSE.
  always_comb begin
    state_d = state_q;
    clr_acc = 1'b0;
    snap    = 1'b0;
    case (state_q)
      S_IDLE:  if (start_stop) state_d = S_RUN;
      S_RUN: begin
        if (start_stop) state_d = S_PAUSE;
        else if (lap) begin
          state_d = S_LAP;
          snap    = 1'b1;
        end
      end
      S_LAP: begin
        if (start_stop) state_d = S_PAUSE;
        else if (lap)   state_d = S_RUN;
      end
      S_PAUSE: begin
        if (clear) begin
          state_d = S_IDLE;
          clr_acc = 1'b1;
        end else if (start_stop) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign adv  = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick = adv && (pre_q == PW'(DIV - 1));

  always_comb begin
    pre_d = pre_q;
    if (clr_acc || state_q == S_IDLE) pre_d = '0;
    else if (adv)                     pre_d = tick ? '0 : pre_q + PW'(1);
  end

  assign en[0] = tick;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
    bcd_digit u_dig (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr_acc),
      .en    (en[g]),
      .q     (cnt[g]),
      .carry (en[g+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_q   <= '0;
      ovf_q   <= 1'b0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      if (clr_acc)              ovf_q <= 1'b0;
      else if (en[NUM_DIGITS])  ovf_q <= 1'b1;
      // snapshot takes the pre-increment count even if tick fires this edge
      if (snap) lap_q <= cnt;
    end
  end

  assign disp       = (state_q == S_LAP) ? lap_q : cnt;
  assign q0         = disp[0];
  assign q1         = disp[1];
  assign q2         = disp[2];
  assign q3         = disp[3];
  assign running    = adv;
  assign lap_active = (state_q == S_LAP);
  assign overflow   = ovf_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with an integer-level reference model.
module tb_stopwatch_ctrl;
  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic clk, rst, start_stop, clear, lap;
  logic [3:0] q0, q1, q2, q3;
  logic running, lap_active, overflow;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear), .lap(lap),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .running(running), .lap_active(lap_active), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: count as a plain integer, wrap at 10000
  int m_mode, m_pre, m_cnt, m_lap;
  bit m_ov;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE; m_pre = 0; m_cnt = 0; m_lap = 0; m_ov = 0;
    end else begin
      int  nxt;
      bit  running_now, tk, clr_acc;
      nxt = m_mode;
      clr_acc = 0;
      running_now = (m_mode == M_RUN) || (m_mode == M_LAP);
      tk = running_now && (m_pre == DIV - 1);
      if (m_mode == M_IDLE && start_stop) nxt = M_RUN;
      if (m_mode == M_RUN) begin
        if (start_stop) nxt = M_PAUSE;
        else if (lap) begin nxt = M_LAP; m_lap = m_cnt; end
      end
      if (m_mode == M_LAP) begin
        if (start_stop) nxt = M_PAUSE;
        else if (lap) nxt = M_RUN;
      end
      if (m_mode == M_PAUSE) begin
        if (clear) begin nxt = M_IDLE; clr_acc = 1; end
        else if (start_stop) nxt = M_RUN;
      end
      if (tk) begin
        m_cnt = (m_cnt + 1) % 10000;
        if (m_cnt == 0) m_ov = 1;
      end
      if (m_mode == M_IDLE || clr_acc) m_pre = 0;
      else if (running_now) m_pre = (m_pre + 1) % DIV;
      if (clr_acc) begin m_cnt = 0; m_ov = 0; end
      m_mode = nxt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dval();
    return q3 * 1000 + q2 * 100 + q1 * 10 + q0;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      int disp;
      disp = (m_mode == M_LAP) ? m_lap : m_cnt;
      chk("model_q0", q0, disp % 10);
      chk("model_q1", q1, (disp / 10) % 10);
      chk("model_q2", q2, (disp / 100) % 10);
      chk("model_q3", q3, (disp / 1000) % 10);
      chk("model_running", running, (m_mode == M_RUN || m_mode == M_LAP) ? 1 : 0);
      chk("model_lap_active", lap_active, (m_mode == M_LAP) ? 1 : 0);
      chk("model_overflow", overflow, m_ov);
    end
  end

  task automatic step(input bit ss, input bit cl, input bit lp);
    start_stop = ss; clear = cl; lap = lp;
    @(posedge clk);
    #1;
    start_stop = 0; clear = 0; lap = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit done;
    rst = 1; start_stop = 0; clear = 0; lap = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_q", dval(), 0);
    chk("reset_running", running, 0);
    chk("reset_overflow", overflow, 0);

    // start at edge 0: 0001 after edge 4, 0003 after edge 12
    step(1, 0, 0);
    idle(3);
    chk("start_edge3", dval(), 0);
    idle(1);
    chk("start_edge4", dval(), 1);
    idle(8);
    chk("start_edge12", dval(), 3);
    chk("start_running", running, 1);

    // pause so the held prescaler phase is 2
    idle(1);
    step(1, 0, 0);
    idle(20);
    chk("pause_hold", dval(), 3);
    chk("pause_running", running, 0);
    step(1, 0, 0);
    idle(1);
    chk("resume_plus1", dval(), 3);
    idle(1);
    chk("resume_plus2", dval(), 4);

    // lap freeze at 0005 while live count reaches 0008
    idle(4);
    chk("pre_lap", dval(), 5);
    idle(1);
    step(0, 0, 1);
    idle(11);
    chk("lap_frozen", dval(), 5);
    chk("lap_active_on", lap_active, 1);
    step(0, 0, 1);
    chk("lap_release", dval(), 8);
    chk("lap_active_off", lap_active, 0);

    // run through the 9999 -> 0000 wrap
    done = 0;
    for (int i = 0; i < 45000 && !done; i++) begin
      idle(1);
      if (overflow) done = 1;
    end
    chk("wrap_reached", done, 1);
    chk("wrap_q", dval(), 0);
    chk("wrap_overflow", overflow, 1);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("clear_overflow", overflow, 0);
    chk("clear_running", running, 0);
    chk("clear_q", dval(), 0);
    idle(5);
    chk("idle_stays", running, 0);

    // clear beats start_stop in PAUSE
    step(1, 0, 0);
    idle(6);
    step(1, 0, 0);
    chk("simul_pause_q", dval(), 1);
    step(1, 1, 0);
    chk("simul_clr_running", running, 0);
    chk("simul_clr_q", dval(), 0);

    // start_stop beats lap in RUN; clear ignored in RUN
    step(1, 0, 0);
    idle(5);
    step(1, 0, 1);
    chk("simul_sslap_running", running, 0);
    chk("simul_sslap_lap", lap_active, 0);
    step(1, 0, 0);
    step(0, 1, 0);
    chk("clear_in_run_running", running, 1);
    chk("clear_in_run_q", dval(), 1);

    // asynchronous reset between edges
    idle(7);
    #2 rst = 1;
    #1;
    chk("arst_running", running, 0);
    chk("arst_q", dval(), 0);
    chk("arst_lap", lap_active, 0);
    chk("arst_overflow", overflow, 0);
    @(negedge clk) rst = 0;
    idle(10);
    chk("post_rst_idle", running, 0);
    chk("post_rst_q", dval(), 0);
    step(1, 0, 0);
    chk("post_rst_start", running, 1);
    idle(4);
    chk("post_rst_first", dval(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
